// File: rtl/div_stream_if.sv
// Handshake bundle between a producer/consumer and div_stream_interface.
// The master side writes operand words and observes results; the slave side
// is the divider block itself.
interface div_stream_if #(
  parameter int DATA_W  = 8,
  parameter int FIFO_AW = 4
);
  logic                  write_req;
  logic [2*DATA_W-1:0]   fifo_write_data;
  logic                  full_out;
  logic [FIFO_AW:0]      level;
  logic                  full_in;
  logic                  done_sig;
  logic [2*DATA_W-1:0]   product;
  logic                  div_zero;

  modport master (
    output write_req, fifo_write_data, full_in,
    input  full_out, level, done_sig, product, div_zero
  );

  modport slave (
    input  write_req, fifo_write_data, full_in,
    output full_out, level, done_sig, product, div_zero
  );
endinterface

// File: rtl/div_stream_interface.sv
// FIFO-fed sequential restoring divider.
// Operand words {dividend, divisor} queue in an internal FIFO; each word is
// divided MSB-first, one quotient bit per cycle, and {quotient, remainder}
// is handed downstream with a one-cycle done_sig write-enable pulse that
// waits for the downstream full_in to clear.
module div_stream_interface #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  div_stream_if.slave   bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(DATA_W - 1);
  localparam logic [FIFO_AW:0]   DEPTH_L   = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t                state_r, state_s;

  logic [2*DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [FIFO_AW:0]      level_r;
  logic [2*DATA_W-1:0]   rd_data_r;
  logic                  full_s, empty_s, wr_en_s, rd_en_s;

  // quo_r starts as the dividend; its MSB feeds the remainder each step while
  // the new quotient bit enters at the LSB, so after DATA_W steps it holds q.
  logic [DATA_W-1:0]     dsr_r, quo_r;
  logic [DATA_W:0]       rem_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  dz_r;

  logic [DATA_W:0]       rem_shift_s, rem_next_s, dsr_ext_s;
  logic                  ge_s;
  logic                  emit_s;

  logic                  done_r, div_zero_r;
  logic [2*DATA_W-1:0]   product_r;

  assign full_s  = (level_r == DEPTH_L);
  assign empty_s = (level_r == {(FIFO_AW+1){1'b0}});
  assign wr_en_s = bus.write_req && !full_s;
  assign rd_en_s = (state_r == IDLE) && !empty_s;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    dsr_ext_s   = {1'b0, dsr_r};
    rem_shift_s = (rem_r << 1) | {{DATA_W{1'b0}}, quo_r[DATA_W-1]};
    ge_s        = (rem_shift_s >= dsr_ext_s);
    if (ge_s) begin
      rem_next_s = rem_shift_s - dsr_ext_s;
    end else begin
      rem_next_s = rem_shift_s;
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.fifo_write_data;
    end
  end

  // FIFO pointers, occupancy and registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= {FIFO_AW{1'b0}};
      rd_ptr_r  <= {FIFO_AW{1'b0}};
      level_r   <= {(FIFO_AW+1){1'b0}};
      rd_data_r <= {(2*DATA_W){1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + FIFO_AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r  <= rd_ptr_r + FIFO_AW'(1);
        rd_data_r <= mem_r[rd_ptr_r];
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + (FIFO_AW+1)'(1);
        2'b01:   level_r <= level_r - (FIFO_AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and result-emit decode.
  always_comb begin
    state_s = state_r;
    emit_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (rd_data_r[DATA_W-1:0] == {DATA_W{1'b0}}) begin
          state_s = OUT;
        end else begin
          state_s = CALC;
        end
      end
      CALC: begin
        if (cnt_r == LAST_STEP) begin
          state_s = OUT;
        end else begin
          state_s = CALC;
        end
      end
      OUT: begin
        if (!bus.full_in) begin
          emit_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Divider datapath: operand latch in LOAD, one restoring step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsr_r <= {DATA_W{1'b0}};
      quo_r <= {DATA_W{1'b0}};
      rem_r <= {(DATA_W+1){1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      dz_r  <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          dsr_r <= rd_data_r[DATA_W-1:0];
          cnt_r <= {CNT_W{1'b0}};
          if (rd_data_r[DATA_W-1:0] == {DATA_W{1'b0}}) begin
            quo_r <= {DATA_W{1'b1}};
            rem_r <= {1'b0, rd_data_r[2*DATA_W-1:DATA_W]};
            dz_r  <= 1'b1;
          end else begin
            quo_r <= rd_data_r[2*DATA_W-1:DATA_W];
            rem_r <= {(DATA_W+1){1'b0}};
            dz_r  <= 1'b0;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= {quo_r[DATA_W-2:0], ge_s};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Registered outputs: results update only on the done edge and then hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r     <= 1'b0;
      product_r  <= {(2*DATA_W){1'b0}};
      div_zero_r <= 1'b0;
    end else begin
      done_r <= emit_s;
      if (emit_s) begin
        product_r  <= {quo_r, rem_r[DATA_W-1:0]};
        div_zero_r <= dz_r;
      end
    end
  end

  assign bus.full_out = full_s;
  assign bus.level    = level_r;
  assign bus.done_sig = done_r;
  assign bus.product  = product_r;
  assign bus.div_zero = div_zero_r;

endmodule
